// File: rtl/spi_slave_if.sv
// Mode-0 SPI responder: oversamples sclk/ss_n/mosi in the clk_i domain, receives MOSI bytes and
// returns a preloaded word on MISO, with a one-cycle done tick per completed byte.
module spi_slave_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  load_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  spi_done_tick_o,
    output logic                  ready_o,
    output logic                  busy_o,
    input  logic                  sclk_i,
    input  logic                  ss_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sclk_d1_q, ss_d1_q;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

    state_e                 state_q;
    logic [DATA_WIDTH-1:0]  tx_buf_q;
    logic                   pending_q;
    logic [DATA_WIDTH-2:0]  tx_sr_q;
    logic [DATA_WIDTH-2:0]  rx_q;
    logic [CntW-1:0]        cnt_q;
    logic                   reload_q;
    logic [DATA_WIDTH-1:0]  dout_q;
    logic                   tick_q;
    logic                   miso_q;

    logic [DATA_WIDTH-1:0]  load_word;
    logic [DATA_WIDTH-1:0]  rx_next;
    logic                   byte_start;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_d1_q   <= 1'b0;
            ss_d1_q     <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_d1_q   <= sclk_s;
            ss_d1_q     <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d1_q;
    assign sclk_fall = ~sclk_s & sclk_d1_q;
    assign ss_fall   = ~ss_s & ss_d1_q;
    assign ss_rise   = ss_s & ~ss_d1_q;

    // An empty holding buffer sends zeros; the buffer itself is left alone.
    assign load_word  = pending_q ? tx_buf_q : '0;
    assign byte_start = ((state_q == StIdle) && ss_fall) ||
                        ((state_q == StShift) && !ss_rise && sclk_fall && reload_q);
    assign rx_next    = {rx_q, mosi_s};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_buf_q  <= '0;
            pending_q <= 1'b0;
        end else if (load_i) begin
            tx_buf_q  <= din_i;
            pending_q <= 1'b1;
        end else if (byte_start) begin
            pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            tx_sr_q  <= '0;
            rx_q     <= '0;
            cnt_q    <= '0;
            reload_q <= 1'b0;
            dout_q   <= '0;
            tick_q   <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ss_fall) begin
                        tx_sr_q  <= load_word[DATA_WIDTH-2:0];
                        miso_q   <= load_word[DATA_WIDTH-1];
                        cnt_q    <= '0;
                        reload_q <= 1'b0;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    // Deselect wins over a coincident sclk edge, discarding any partial byte.
                    if (ss_rise) begin
                        state_q  <= StIdle;
                        miso_q   <= 1'b0;
                        cnt_q    <= '0;
                        reload_q <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_q <= rx_next[DATA_WIDTH-2:0];
                        if (cnt_q == LastBit) begin
                            dout_q   <= rx_next;
                            tick_q   <= 1'b1;
                            cnt_q    <= '0;
                            reload_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (reload_q) begin
                            tx_sr_q  <= load_word[DATA_WIDTH-2:0];
                            miso_q   <= load_word[DATA_WIDTH-1];
                            reload_q <= 1'b0;
                        end else begin
                            miso_q  <= tx_sr_q[DATA_WIDTH-2];
                            tx_sr_q <= tx_sr_q << 1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dout_o          = dout_q;
    assign spi_done_tick_o = tick_q;
    assign ready_o         = ~pending_q;
    assign busy_o          = (state_q == StShift);
    assign miso_o          = miso_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a mode-0 master with an 8-cycle sclk period, checked against
// hand-computed bytes, tick timing and buffer flags.
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] din_i = 8'h00;
    logic       load_i = 1'b0;
    logic [7:0] dout_o;
    logic       tick;
    logic       ready;
    logic       busy;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;

    int         checks = 0;
    int         errors = 0;
    int         cyc_n = 0;
    int         tick_cnt = 0;
    int         tick_at = 0;
    int         rise_cyc = 0;
    logic [7:0] tick_dout = 8'h00;

    always #5 clk = ~clk;

    spi_slave_if #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .din_i          (din_i),
        .load_i         (load_i),
        .dout_o         (dout_o),
        .spi_done_tick_o(tick),
        .ready_o        (ready),
        .busy_o         (busy),
        .sclk_i         (sclk),
        .ss_n_i         (ss_n),
        .mosi_i         (mosi),
        .miso_o         (miso)
    );

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (tick === 1'b1) begin
            tick_cnt++;
            tick_at   = cyc_n;
            tick_dout = dout_o;
        end
    endtask

    task automatic load_word(input logic [7:0] v);
        load_i = 1'b1;
        din_i  = v;
        cyc();
        load_i = 1'b0;
    endtask

    task automatic ss_begin();
        ss_n = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic ss_end();
        repeat (4) cyc();
        ss_n = 1'b1;
        repeat (4) cyc();
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, input bit desel_last,
                        input bit do_load, input logic [7:0] lval, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            mosi = tx[7-b];
            repeat (4) cyc();
            rx[7-b] = miso;
            sclk = 1'b1;
            rise_cyc = cyc_n;
            if (desel_last && b == nbits - 1) ss_n = 1'b1;
            for (int j = 0; j < 4; j++) begin
                cyc();
                if (do_load && b == nbits - 1 && j == 2) begin
                    load_i = 1'b1;
                    din_i  = lval;
                end
                if (j == 3) load_i = 1'b0;
            end
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        rst_i = 1'b0;
        cyc();
        checks++; if (dout_o !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout_o); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", miso); end
    endtask

    task automatic test_single_frame();
        int t0;
        logic [7:0] rx;
        t0 = tick_cnt;
        load_word(8'hA5);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_ready_load: got %b want 0", ready); end
        ss_n = 1'b0;
        cyc(); cyc();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_ready_ss2: got %b want 0", ready); end
        cyc();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_ss3: got %b want 1", ready); end
        checks++; if (miso !== 1'b1) begin errors++; $display("FAIL single_miso_msb: got %b want 1", miso); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        cyc();
        xfer(8'h3C, 8, 1'b0, 1'b0, 8'h00, rx);
        checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL single_miso_byte: got %h want a5", rx); end
        checks++; if (tick_cnt !== t0 + 1) begin errors++; $display("FAIL single_ticks: got %0d want %0d", tick_cnt - t0, 1); end
        checks++; if (tick_at !== rise_cyc + 3) begin errors++; $display("FAIL single_tick_lat: got %0d want 3", tick_at - rise_cyc); end
        checks++; if (tick_dout !== 8'h3C) begin errors++; $display("FAIL single_tick_dout: got %h want 3c", tick_dout); end
        ss_end();
        checks++; if (dout_o !== 8'h3C) begin errors++; $display("FAIL single_dout: got %h want 3c", dout_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int t0;
        int first;
        logic [7:0] rx1, rx2, d1;
        t0 = tick_cnt;
        load_word(8'h81);
        ss_begin();
        xfer(8'hFF, 8, 1'b0, 1'b1, 8'h7E, rx1);
        first = tick_at;
        d1 = tick_dout;
        xfer(8'h00, 8, 1'b0, 1'b0, 8'h00, rx2);
        ss_end();
        checks++; if (rx1 !== 8'h81) begin errors++; $display("FAIL b2b_miso1: got %h want 81", rx1); end
        checks++; if (rx2 !== 8'h7E) begin errors++; $display("FAIL b2b_miso2: got %h want 7e", rx2); end
        checks++; if (d1 !== 8'hFF) begin errors++; $display("FAIL b2b_dout1: got %h want ff", d1); end
        checks++; if (tick_dout !== 8'h00) begin errors++; $display("FAIL b2b_dout2: got %h want 00", tick_dout); end
        checks++; if (tick_cnt !== t0 + 2) begin errors++; $display("FAIL b2b_ticks: got %0d want 2", tick_cnt - t0); end
        checks++; if (tick_at - first !== 64) begin errors++; $display("FAIL b2b_spacing: got %0d want 64", tick_at - first); end
    endtask

    task automatic test_underrun_overwrite();
        logic [7:0] rx;
        ss_begin();
        xfer(8'h55, 8, 1'b0, 1'b0, 8'h00, rx);
        checks++; if (rx !== 8'h00) begin errors++; $display("FAIL underrun_miso: got %h want 00", rx); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL underrun_ready: got %b want 1", ready); end
        ss_end();
        checks++; if (dout_o !== 8'h55) begin errors++; $display("FAIL underrun_dout: got %h want 55", dout_o); end
        load_word(8'h11);
        load_word(8'h22);
        ss_begin();
        xfer(8'h96, 8, 1'b0, 1'b0, 8'h00, rx);
        checks++; if (rx !== 8'h22) begin errors++; $display("FAIL overwrite_miso: got %h want 22", rx); end
        ss_end();
        checks++; if (dout_o !== 8'h96) begin errors++; $display("FAIL overwrite_dout: got %h want 96", dout_o); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL overwrite_ready: got %b want 1", ready); end
    endtask

    task automatic test_abort();
        int t0;
        logic [7:0] rx;
        t0 = tick_cnt;
        ss_begin();
        xfer(8'hC3, 5, 1'b0, 1'b0, 8'h00, rx);
        ss_end();
        checks++; if (tick_cnt !== t0) begin errors++; $display("FAIL abort_ticks: got %0d want 0", tick_cnt - t0); end
        checks++; if (dout_o !== 8'h96) begin errors++; $display("FAIL abort_dout: got %h want 96", dout_o); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL abort_miso: got %b want 0", miso); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        ss_begin();
        xfer(8'h5A, 8, 1'b0, 1'b0, 8'h00, rx);
        ss_end();
        checks++; if (dout_o !== 8'h5A) begin errors++; $display("FAIL abort_next_dout: got %h want 5a", dout_o); end
        checks++; if (tick_cnt !== t0 + 1) begin errors++; $display("FAIL abort_next_ticks: got %0d want 1", tick_cnt - t0); end
    endtask

    task automatic test_collision();
        int t0;
        logic [7:0] rx;
        t0 = tick_cnt;
        ss_begin();
        xfer(8'hE7, 8, 1'b1, 1'b0, 8'h00, rx);
        repeat (4) cyc();
        checks++; if (tick_cnt !== t0) begin errors++; $display("FAIL coll_ss_ticks: got %0d want 0", tick_cnt - t0); end
        checks++; if (dout_o !== 8'h5A) begin errors++; $display("FAIL coll_ss_dout: got %h want 5a", dout_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coll_ss_busy: got %b want 0", busy); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL coll_ss_miso: got %b want 0", miso); end
        load_word(8'h33);
        ss_n = 1'b0;
        cyc(); cyc();
        load_i = 1'b1;
        din_i  = 8'h44;
        cyc();
        load_i = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL coll_load_ready: got %b want 0", ready); end
        cyc();
        xfer(8'h0F, 8, 1'b0, 1'b0, 8'h00, rx);
        checks++; if (rx !== 8'h33) begin errors++; $display("FAIL coll_load_miso: got %h want 33", rx); end
        ss_end();
        checks++; if (dout_o !== 8'h0F) begin errors++; $display("FAIL coll_load_dout: got %h want 0f", dout_o); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL coll_load_ready_end: got %b want 1", ready); end
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        logic [7:0] rx;
        t0 = tick_cnt;
        load_word(8'h99);
        ss_begin();
        xfer(8'hAA, 5, 1'b0, 1'b0, 8'h00, rx);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre: got %b want 1", busy); end
        rst_i = 1'b1;
        cyc(); cyc();
        checks++; if (dout_o !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got %h want 00", dout_o); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b want 0", miso); end
        ss_n = 1'b1;
        cyc();
        rst_i = 1'b0;
        repeat (4) cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_post: got %b want 0", busy); end
        checks++; if (tick_cnt !== t0) begin errors++; $display("FAIL rstmid_ticks: got %0d want 0", tick_cnt - t0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_underrun_overwrite();
        test_abort();
        test_collision();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
